// File: rtl/lightgun_pkg.sv
// lightgun_pkg: shared constants and types for the light-gun controller port.
//   - MODE encodings for the port device
//   - pin bit indices within the 7-bit {TH,TR,TL,D3,D2,D1,D0} port word
//   - HL latch-request FSM state type
package lightgun_pkg;

    localparam logic [1:0] ModeNone      = 2'd0;
    localparam logic [1:0] ModeMenacer   = 2'd1;
    localparam logic [1:0] ModeJustifier = 2'd2;
    localparam logic [1:0] ModeNoneAlt   = 2'd3;

    localparam int unsigned PinTh = 6;
    localparam int unsigned PinTr = 5;
    localparam int unsigned PinTl = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StPulse  = 2'd1,
        StLocked = 2'd2
    } hl_state_e;

    // True for the modes that have a gun attached and may request a latch.
    function automatic logic mode_has_gun(input logic [1:0] mode);
        return (mode == ModeMenacer) || (mode == ModeJustifier);
    endfunction

endpackage

// File: rtl/lightgun_port_if.sv
// lightgun_port_if: groups the controller-port signals between the console side
// (master: drives device/CPU inputs, reads pins) and the port stage (slave).
//   MODE, SENSOR, BTN, VBLANK, PORT_OUT, PORT_DIR, HL_EN : console -> port
//   PORT_IN, HL, GUN_SEL                                  : port -> console
interface lightgun_port_if;

    logic [1:0] MODE;
    logic [1:0] SENSOR;
    logic [7:0] BTN;
    logic       VBLANK;
    logic [6:0] PORT_OUT;
    logic [6:0] PORT_DIR;
    logic       HL_EN;
    logic [6:0] PORT_IN;
    logic       HL;
    logic       GUN_SEL;

    modport master (
        output MODE, SENSOR, BTN, VBLANK, PORT_OUT, PORT_DIR, HL_EN,
        input  PORT_IN, HL, GUN_SEL
    );

    modport slave (
        input  MODE, SENSOR, BTN, VBLANK, PORT_OUT, PORT_DIR, HL_EN,
        output PORT_IN, HL, GUN_SEL
    );

endinterface

// File: rtl/lightgun_port_sync_edge.sv
// sync_edge: multi-flop synchronizer for one asynchronous sensor bit followed by a
// rising-edge detector.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   d_i          : raw asynchronous input
//   level_o      : synchronized level
//   rise_o       : one-cycle pulse on a synchronized 0->1 transition
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/lightgun_port.sv
// lightgun_port: controller-port stage for Menacer / Justifier light guns.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus (slave)  : MODE, SENSOR, BTN, VBLANK, PORT_OUT, PORT_DIR, HL_EN in;
//                  PORT_IN (registered pin word), HL (active-low latch request),
//                  GUN_SEL (registered selected gun) out
// HL is pulsed low for HL_WIDTH cycles on the first accepted sensor hit per frame;
// further hits are ignored until the next VBLANK rising edge.
module lightgun_port
    import lightgun_pkg::*;
#(
    parameter int unsigned HL_WIDTH    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic            CLK,
    input logic            RESET_N,
    lightgun_port_if.slave bus
);

    logic [1:0] sens_level;
    logic [1:0] sens_rise;

    for (genvar g = 0; g < 2; g++) begin : g_gun
        sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .CLK    (CLK),
            .RESET_N(RESET_N),
            .d_i    (bus.SENSOR[g]),
            .level_o(sens_level[g]),
            .rise_o (sens_rise[g])
        );
    end

    // ------------------------------------------------------------------
    // Gun selection and pin mux
    // ------------------------------------------------------------------
    logic       gun_sel_d, gun_sel_q;
    logic [6:0] pins;
    logic [6:0] port_in_d, port_in_q;

    always_comb begin
        gun_sel_d = 1'b0;
        if (bus.MODE == ModeJustifier) begin
            gun_sel_d = bus.PORT_DIR[PinTr] & bus.PORT_OUT[PinTr];
        end

        pins = 7'h7F;
        case (bus.MODE)
            ModeMenacer: begin
                pins = {~sens_level[0], 1'b1, 1'b1, ~bus.BTN[3:0]};
            end
            ModeJustifier: begin
                pins = {~sens_level[gun_sel_d], 1'b1, 1'b1,
                        gun_sel_d ? ~bus.BTN[7:4] : ~bus.BTN[3:0]};
            end
            default: pins = 7'h7F;
        endcase

        // Console-driven pins read back the CPU's own output value.
        port_in_d = (bus.PORT_DIR & bus.PORT_OUT) | (~bus.PORT_DIR & pins);
    end

    // ------------------------------------------------------------------
    // Change / edge detection feeding the HL FSM
    // ------------------------------------------------------------------
    logic       vblank_q;
    logic [1:0] mode_q;
    logic       mode_vld_q;
    logic       vblank_rise;
    logic       mode_chg;
    logic       gun_chg;
    logic       accept;

    assign vblank_rise = bus.VBLANK & ~vblank_q;
    // The first cycle after reset only captures MODE; it is not a change.
    assign mode_chg    = mode_vld_q & (bus.MODE != mode_q);
    assign gun_chg     = gun_sel_d != gun_sel_q;
    assign accept      = sens_rise[gun_sel_q] & mode_has_gun(bus.MODE) & bus.HL_EN &
                         ~bus.PORT_DIR[PinTh];

    // ------------------------------------------------------------------
    // HL FSM
    // ------------------------------------------------------------------
    hl_state_e  state_d, state_q;
    logic [3:0] cnt_d, cnt_q;
    logic       vb_seen_d, vb_seen_q;
    logic       hl_d, hl_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vb_seen_d = vb_seen_q;

        if (mode_chg || gun_chg) begin
            // Device or gun swapped: lock out until the next frame.
            state_d   = StLocked;
            vb_seen_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d   = StPulse;
                        cnt_d     = 4'd0;
                        vb_seen_d = 1'b0;
                    end
                end
                StPulse: begin
                    if (!bus.HL_EN) begin
                        state_d = StLocked;
                    end else if (cnt_q == 4'(HL_WIDTH - 1)) begin
                        // A frame boundary during the pulse re-arms the latch.
                        state_d = (vb_seen_q || vblank_rise) ? StIdle : StLocked;
                    end else begin
                        cnt_d     = cnt_q + 4'd1;
                        vb_seen_d = vb_seen_q | vblank_rise;
                    end
                end
                StLocked: begin
                    // VBLANK re-arms first, so a coincident hit is still taken.
                    if (vblank_rise) begin
                        state_d   = accept ? StPulse : StIdle;
                        cnt_d     = 4'd0;
                        vb_seen_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        hl_d = (state_d != StPulse);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            vb_seen_q  <= 1'b0;
            hl_q       <= 1'b1;
            vblank_q   <= 1'b0;
            mode_q     <= ModeNone;
            mode_vld_q <= 1'b0;
            gun_sel_q  <= 1'b0;
            port_in_q  <= 7'h7F;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vb_seen_q  <= vb_seen_d;
            hl_q       <= hl_d;
            vblank_q   <= bus.VBLANK;
            mode_q     <= bus.MODE;
            mode_vld_q <= 1'b1;
            gun_sel_q  <= gun_sel_d;
            port_in_q  <= port_in_d;
        end
    end

    assign bus.PORT_IN = port_in_q;
    assign bus.HL      = hl_q;
    assign bus.GUN_SEL = gun_sel_q;

endmodule
